seq_alu: RTL and testbench

//  Parametrised, registered ALU for the next microcontroller core generation. Accepts one

---
 rtl/seq_alu_pkg.sv | 38 +++
 rtl/seq_alu_core.sv | 70 +++++++
 rtl/seq_alu.sv | 198 +++++++++++++++++++
 tb/tb_seq_alu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: mode codes, flag bit positions, FSM state encoding.
package seq_alu_pkg;

  localparam logic [4:0] ALU_ADD   = 5'h00;
  localparam logic [4:0] ALU_SUB   = 5'h01;
  localparam logic [4:0] ALU_PASS1 = 5'h02;
  localparam logic [4:0] ALU_PASS2 = 5'h03;
  localparam logic [4:0] ALU_AND   = 5'h04;
  localparam logic [4:0] ALU_OR    = 5'h05;
  localparam logic [4:0] ALU_XOR   = 5'h06;
  localparam logic [4:0] ALU_RSUB  = 5'h07;
  localparam logic [4:0] ALU_INC   = 5'h08;
  localparam logic [4:0] ALU_DEC   = 5'h09;
  localparam logic [4:0] ALU_ROL   = 5'h0A;
  localparam logic [4:0] ALU_ROR   = 5'h0B;
  localparam logic [4:0] ALU_SHL   = 5'h0C;
  localparam logic [4:0] ALU_SHR   = 5'h0D;
  localparam logic [4:0] ALU_ASR   = 5'h0E;
  localparam logic [4:0] ALU_NEG   = 5'h0F;
  localparam logic [4:0] ALU_MUL   = 5'h10;

  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_S = 1;
  localparam int FLG_O = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_MUL   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Base-set shifts and rotates (A..E) iterate; everything else is single-cycle or MUL.
  function automatic logic is_shift(input logic [4:0] mode);
    return (mode >= ALU_ROL) && (mode <= ALU_ASR);
  endfunction

endpackage

// File: rtl/seq_alu_core.sv
// Combinational single-cycle datapath for seq_alu: base ops 0-9 and F, plus the
// pass-Operand2 fallback used for any mode it does not implement.
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [4:0]       mode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] ext1;
  logic [WIDTH:0] ext2;
  logic [WIDTH:0] wide;

  // wide[WIDTH] is carry for additions and borrow for subtractions.
  always_comb begin
    ext1 = {1'b0, op1};
    ext2 = {1'b0, op2};
    wide = ext2;
    c    = 1'b0;
    o    = 1'b0;
    case (mode)
      ALU_ADD: begin
        wide = ext1 + ext2;
        c    = wide[WIDTH];
        o    = (op1[MSB] == op2[MSB]) && (wide[MSB] != op1[MSB]);
      end
      ALU_SUB: begin
        wide = ext1 - ext2;
        c    = ~wide[WIDTH];
        o    = (op1[MSB] != op2[MSB]) && (wide[MSB] != op1[MSB]);
      end
      ALU_RSUB: begin
        wide = ext2 - ext1;
        c    = ~wide[WIDTH];
        o    = (op1[MSB] != op2[MSB]) && (wide[MSB] != op2[MSB]);
      end
      ALU_PASS1: wide = ext1;
      ALU_PASS2: wide = ext2;
      ALU_AND:   wide = {1'b0, op1 & op2};
      ALU_OR:    wide = {1'b0, op1 | op2};
      ALU_XOR:   wide = {1'b0, op1 ^ op2};
      ALU_INC: begin
        wide = ext2 + (WIDTH+1)'(1);
        c    = wide[WIDTH];
        o    = ~op2[MSB] & wide[MSB];
      end
      ALU_DEC: begin
        wide = ext2 - (WIDTH+1)'(1);
        c    = ~wide[WIDTH];
        o    = op2[MSB] & ~wide[MSB];
      end
      ALU_NEG: begin
        wide = '0 - ext2;
        c    = ~wide[WIDTH];
        o    = op2[MSB] & wide[MSB];
      end
      default: wide = ext2;
    endcase
    res = wide[MSB:0];
  end

endmodule

// File: rtl/seq_alu.sv
// Registered sequential ALU: valid/ready in, valid/ready out, FSM-driven execution.
// Optional SEQ_ALU_MUL_EN adds an iterative unsigned multiply on Mode 5'b10000.
//
// Handshake: an op is accepted on a rising edge with in_valid && in_ready (in_ready only in
// IDLE); the result is offered with out_valid (only in DONE) and held until out_ready.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       Mode,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [3:0]       Flags
);

  localparam int CNT_W = SHW + 1;
  localparam int MSB   = WIDTH - 1;

  logic [2:0]       state_q, state_d;
  logic [4:0]       mode_q, mode_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             car_q, car_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] core_res;
  logic             core_c;
  logic             core_o;

  logic             fin_load;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;
  logic             fin_o;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] mul_hi_q, mul_hi_d;
  logic [WIDTH:0]   mul_sum;
`endif

  seq_alu_core #(.WIDTH(WIDTH)) u_core (
    .mode (mode_q),
    .op1  (op1_q),
    .op2  (op2_q),
    .res  (core_res),
    .c    (core_c),
    .o    (core_o)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    car_d    = car_q;
    out_d    = out_q;
    flags_d  = flags_q;
    fin_load = 1'b0;
    fin_res  = '0;
    fin_c    = 1'b0;
    fin_o    = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    mul_hi_d = mul_hi_q;
    mul_sum  = {1'b0, mul_hi_q} + (sh_q[0] ? {1'b0, op1_q} : '0);
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d = Mode;
          op1_d  = Operand1;
          op2_d  = Operand2;
          sh_d   = Operand2;
          cnt_d  = {1'b0, Operand1[SHW-1:0]};
          car_d  = 1'b0;
          if (is_shift(Mode)) begin
            state_d = ST_SHIFT;
`ifdef SEQ_ALU_MUL_EN
          end else if (Mode == ALU_MUL) begin
            state_d  = ST_MUL;
            cnt_d    = CNT_W'(WIDTH);
            mul_hi_d = '0;
`endif
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        fin_load = 1'b1;
        fin_res  = core_res;
        fin_c    = core_c;
        fin_o    = core_o;
        state_d  = ST_DONE;
      end

      ST_SHIFT: begin
        if (cnt_q == '0) begin
          fin_load = 1'b1;
          fin_res  = sh_q;
          fin_c    = car_q;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          case (mode_q)
            ALU_ROL: begin sh_d = {sh_q[MSB-1:0], sh_q[MSB]}; car_d = sh_q[MSB]; end
            ALU_ROR: begin sh_d = {sh_q[0], sh_q[MSB:1]};     car_d = sh_q[0];   end
            ALU_SHL: begin sh_d = {sh_q[MSB-1:0], 1'b0};      car_d = sh_q[MSB]; end
            ALU_SHR: begin sh_d = {1'b0, sh_q[MSB:1]};        car_d = sh_q[0];   end
            ALU_ASR: begin sh_d = {sh_q[MSB], sh_q[MSB:1]};   car_d = sh_q[0];   end
            default: sh_d = sh_q;
          endcase
        end
      end

`ifdef SEQ_ALU_MUL_EN
      // Shift-add: {mul_hi, sh} holds the partial product with the multiplier draining from sh.
      ST_MUL: begin
        if (cnt_q == '0) begin
          fin_load = 1'b1;
          fin_res  = sh_q;
          fin_c    = |mul_hi_q;
          state_d  = ST_DONE;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mul_hi_d = mul_sum[WIDTH:1];
          sh_d     = {mul_sum[0], sh_q[MSB:1]};
        end
      end
`endif

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (fin_load) begin
      out_d          = fin_res;
      flags_d[FLG_Z] = (fin_res == '0);
      flags_d[FLG_C] = fin_c;
      flags_d[FLG_S] = fin_res[MSB];
      flags_d[FLG_O] = fin_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      car_q   <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      car_q   <= car_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) mul_hi_q <= '0;
    else     mul_hi_q <= mul_hi_d;
  end
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Out       = out_q;
  assign Flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): vector table plus reset, backpressure and MUL sequences.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   Mode;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Out;
  logic [3:0]   Flags;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    string        name;
    logic [4:0]   mode;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [W-1:0] exp_out;
    logic [3:0]   exp_flags;
    int           exp_lat;
  } vec_t;

  vec_t vecs[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Mode      (Mode),
    .Operand1  (Operand1),
    .Operand2  (Operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .Flags     (Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one op, scrambles inputs after the accept edge, waits for out_valid and consumes it.
  task automatic run_op(input logic [4:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic [3:0] flg, output int lat);
    int waitc;
    @(negedge clk);
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    Mode      = m;
    Operand1  = a;
    Operand2  = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    Mode     = 5'($urandom_range(0, 31));
    Operand1 = W'($urandom_range(0, 255));
    Operand2 = W'($urandom_range(0, 255));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = Out;
    flg = Flags;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic add_vec(input string n, input logic [4:0] m, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eo, input logic [3:0] ef,
                         input int el);
    vec_t v;
    v.name = n; v.mode = m; v.op1 = a; v.op2 = b;
    v.exp_out = eo; v.exp_flags = ef; v.exp_lat = el;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] r;
    logic [3:0]   f;
    int           lat;
    logic [W-1:0] exp_o;

    // Flags are {Z,C,S,O}; latency counts cycles from the accept edge to out_valid.
    add_vec("add_ovf",   5'h00, 8'h7F, 8'h01, 8'h80, 4'b0011, 1);
    add_vec("add_carry", 5'h00, 8'hFF, 8'h01, 8'h00, 4'b1100, 1);
    add_vec("sub_borrow",5'h01, 8'h05, 8'h07, 8'hFE, 4'b0010, 1);
    add_vec("sub_ovf",   5'h01, 8'h80, 8'h01, 8'h7F, 4'b0101, 1);
    add_vec("rsub",      5'h07, 8'h10, 8'h30, 8'h20, 4'b0100, 1);
    add_vec("pass1_z",   5'h02, 8'h00, 8'h55, 8'h00, 4'b1000, 1);
    add_vec("pass2",     5'h03, 8'h12, 8'h9C, 8'h9C, 4'b0010, 1);
    add_vec("and",       5'h04, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
    add_vec("or",        5'h05, 8'h0F, 8'hF0, 8'hFF, 4'b0010, 1);
    add_vec("xor_z",     5'h06, 8'hAA, 8'hAA, 8'h00, 4'b1000, 1);
    add_vec("inc_ovf",   5'h08, 8'h00, 8'h7F, 8'h80, 4'b0011, 1);
    add_vec("dec_zero",  5'h09, 8'h00, 8'h00, 8'hFF, 4'b0010, 1);
    add_vec("dec_ovf",   5'h09, 8'h00, 8'h80, 8'h7F, 4'b0101, 1);
    add_vec("neg_min",   5'h0F, 8'h00, 8'h80, 8'h80, 4'b0011, 1);
    add_vec("neg_zero",  5'h0F, 8'h00, 8'h00, 8'h00, 4'b1100, 1);
    add_vec("shr_k3",    5'h0D, 8'h03, 8'h81, 8'h10, 4'b0000, 4);
    add_vec("asr_k1",    5'h0E, 8'h01, 8'h81, 8'hC0, 4'b0110, 2);
    add_vec("rol_k1",    5'h0A, 8'h01, 8'h81, 8'h03, 4'b0100, 2);
    add_vec("ror_k2",    5'h0B, 8'h02, 8'h01, 8'h40, 4'b0000, 3);
    add_vec("shl_k0",    5'h0C, 8'h08, 8'h81, 8'h81, 4'b0010, 1);
    add_vec("shl_k7",    5'h0C, 8'h07, 8'hFF, 8'h80, 4'b0110, 8);
    add_vec("ext_fb",    5'h15, 8'h01, 8'h00, 8'h00, 4'b1000, 1);
`ifdef SEQ_ALU_MUL_EN
    add_vec("mul",       5'h10, 8'h10, 8'h11, 8'h10, 4'b0100, 9);
    add_vec("mul_small", 5'h10, 8'h03, 8'h05, 8'h0F, 4'b0000, 9);
`else
    add_vec("mul_fb",    5'h10, 8'h10, 8'h11, 8'h11, 4'b0000, 1);
`endif

    // Clock/reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Mode = '0; Operand1 = '0; Operand2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(Out), 32'd0);
    check("rst_flags", 32'(Flags), 32'd0);

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_out);
      run_op(vecs[i].mode, vecs[i].op1, vecs[i].op2, r, f, lat);
      exp_o = exp_q.pop_front();
      check({vecs[i].name, "_out"}, 32'(r), 32'(exp_o));
      check({vecs[i].name, "_flags"}, 32'(f), 32'(vecs[i].exp_flags));
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure: result held, new requests refused for 5 cycles.
    @(negedge clk);
    Mode = 5'h00; Operand1 = 8'h01; Operand2 = 8'h02; in_valid = 1'b1;
    @(posedge clk);
    #1;
    Mode = 5'h06; Operand1 = 8'hFF; Operand2 = 8'h0F;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_out", 32'(Out), 32'h03);
      check("bp_flags", 32'(Flags), 32'b0000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_idle", 32'(in_ready), 32'd1);
    check("bp_release_ov", 32'(out_valid), 32'd0);
    exp_q.push_back(8'hF0);
    run_op(5'h06, 8'hFF, 8'h0F, r, f, lat);
    exp_o = exp_q.pop_front();
    check("post_bp_out", 32'(r), 32'(exp_o));
    check("post_bp_flags", 32'(f), 32'b0010);

    // Reset mid-SHIFT: ROL by 5, reset asserted on the second cycle after accept.
    @(negedge clk);
    Mode = 5'h0A; Operand1 = 8'h05; Operand2 = 8'h81; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mid_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(Out), 32'd0);
    check("mid_rst_flags", 32'(Flags), 32'd0);
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    check("mid_rst_aborted", 32'(lat), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
